// File: rtl/sad_buf_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : sad_buf_prefetch
// Description : Prefetch engine for the SAD buffer banks. It fills bank A
//               (window) and bank B (frame) from data memory over a
//               req/gnt/rvalid read port. It refills a bank from the next
//               strided address after each consume, and reports
//               all_buf_flags to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module sad_buf_prefetch #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cfg_start,
    input  logic [31:0]       cfg_addr_a,
    input  logic [31:0]       cfg_addr_b,
    input  logic [31:0]       cfg_stride,
    input  logic              ID_load_buff_a,
    input  logic              ID_load_buff_b,
    input  logic              ID_stall,
    output logic              all_buf_flags,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              buf_we,
    output logic              buf_sel,
    output logic [IDX_W-1:0]  buf_idx,
    output logic [DATA_W-1:0] buf_wdata,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_READY = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_sel;
    logic [IDX_W-1:0] r_count;
    logic [31:0]      r_ptr_a;
    logic [31:0]      r_ptr_b;
    logic [31:0]      r_stride;
    logic             r_valid_a;
    logic             r_valid_b;

    logic             w_cons_a;
    logic             w_cons_b;
    logic             w_fill_last;
    logic             w_outstanding;
    logic [31:0]      w_ptr_a_nx;
    logic [31:0]      w_ptr_b_nx;
    logic             w_valid_a_nx;
    logic             w_valid_b_nx;
    logic             w_need_fill;
    logic             w_next_sel;
    logic [31:0]      w_next_addr;
    logic [IDX_W-1:0] w_cnt_inc;
    logic [31:0]      w_cont_addr;
    logic [31:0]      w_cfg_a_al;
    logic [31:0]      w_cfg_b_al;

    assign all_buf_flags = r_valid_a & r_valid_b;

    // Consume/fill bookkeeping and next-bank choice. A consume on this edge
    // wins over a fill that completes on the same edge.
    always_comb begin
        w_cons_a      = ID_load_buff_a & ~ID_stall;
        w_cons_b      = ID_load_buff_b & ~ID_stall;
        w_fill_last   = (r_state == S_WAIT) & mem_rvalid & (r_count == LAST_IDX);
        w_outstanding = (((r_state == S_WAIT) | (r_state == S_DRAIN)) & ~mem_rvalid)
                      | ((r_state == S_REQ) & mem_gnt);
        w_ptr_a_nx    = w_cons_a ? (r_ptr_a + r_stride) : r_ptr_a;
        w_ptr_b_nx    = w_cons_b ? (r_ptr_b + r_stride) : r_ptr_b;
        w_valid_a_nx  = ~w_cons_a & (r_valid_a | (w_fill_last & ~r_sel));
        w_valid_b_nx  = ~w_cons_b & (r_valid_b | (w_fill_last &  r_sel));
        w_need_fill   = ~w_valid_a_nx | ~w_valid_b_nx;
        w_next_sel    = w_valid_a_nx;
        w_next_addr   = w_next_sel ? w_ptr_b_nx : w_ptr_a_nx;
        w_next_addr   = {w_next_addr[31:2], 2'b00};
        w_cnt_inc     = r_count + 1'b1;
        w_cont_addr   = (r_sel ? w_ptr_b_nx : w_ptr_a_nx)
                      + {{(30-IDX_W){1'b0}}, w_cnt_inc, 2'b00};
        w_cont_addr   = {w_cont_addr[31:2], 2'b00};
        w_cfg_a_al    = {cfg_addr_a[31:2], 2'b00};
        w_cfg_b_al    = {cfg_addr_b[31:2], 2'b00};
    end

    // Fill FSM with registered memory-port, buffer-write and busy outputs.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_sel     <= 1'b0;
            r_count   <= '0;
            r_ptr_a   <= '0;
            r_ptr_b   <= '0;
            r_stride  <= '0;
            r_valid_a <= 1'b0;
            r_valid_b <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            buf_we    <= 1'b0;
            buf_sel   <= 1'b0;
            buf_idx   <= '0;
            buf_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            buf_we    <= 1'b0;
            r_ptr_a   <= w_ptr_a_nx;
            r_ptr_b   <= w_ptr_b_nx;
            r_valid_a <= w_valid_a_nx;
            r_valid_b <= w_valid_b_nx;
            if (cfg_start) begin
                // Restart: a read already granted must be drained and dropped.
                r_ptr_a   <= w_cfg_a_al;
                r_ptr_b   <= w_cfg_b_al;
                r_stride  <= cfg_stride;
                r_valid_a <= 1'b0;
                r_valid_b <= 1'b0;
                r_count   <= '0;
                r_sel     <= 1'b0;
                busy      <= 1'b1;
                if (w_outstanding) begin
                    r_state <= S_DRAIN;
                    mem_req <= 1'b0;
                end else begin
                    r_state  <= S_REQ;
                    mem_req  <= 1'b1;
                    mem_addr <= w_cfg_a_al;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        busy <= 1'b0;
                    end
                    S_READY: begin
                        if (w_need_fill) begin
                            r_state  <= S_REQ;
                            r_sel    <= w_next_sel;
                            r_count  <= '0;
                            mem_req  <= 1'b1;
                            mem_addr <= w_next_addr;
                            busy     <= 1'b1;
                        end
                    end
                    S_REQ: begin
                        if (mem_gnt) begin
                            r_state <= S_WAIT;
                            mem_req <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        if (mem_rvalid) begin
                            buf_we    <= 1'b1;
                            buf_sel   <= r_sel;
                            buf_idx   <= r_count;
                            buf_wdata <= mem_rdata;
                            if (r_count == LAST_IDX) begin
                                r_count <= '0;
                                if (w_need_fill) begin
                                    r_state  <= S_REQ;
                                    r_sel    <= w_next_sel;
                                    mem_req  <= 1'b1;
                                    mem_addr <= w_next_addr;
                                end else begin
                                    r_state <= S_READY;
                                    busy    <= 1'b0;
                                end
                            end else begin
                                r_count  <= w_cnt_inc;
                                r_state  <= S_REQ;
                                mem_req  <= 1'b1;
                                mem_addr <= w_cont_addr;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (mem_rvalid) begin
                            r_count <= '0;
                            if (w_need_fill) begin
                                r_state  <= S_REQ;
                                r_sel    <= w_next_sel;
                                mem_req  <= 1'b1;
                                mem_addr <= w_next_addr;
                            end else begin
                                r_state <= S_READY;
                                busy    <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sad_buf_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_sad_buf_prefetch
// Description : Directed self-checking bench for sad_buf_prefetch (DEPTH=4)
//               with a configurable-latency read memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sad_buf_prefetch;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_addr_a = '0;
    logic [31:0] cfg_addr_b = '0;
    logic [31:0] cfg_stride = '0;
    logic        ID_load_buff_a = 1'b0;
    logic        ID_load_buff_b = 1'b0;
    logic        ID_stall = 1'b0;
    logic        all_buf_flags;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        buf_we;
    logic        buf_sel;
    logic [1:0]  buf_idx;
    logic [31:0] buf_wdata;
    logic        busy;

    sad_buf_prefetch #(.DEPTH(4), .IDX_W(2), .DATA_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .cfg_start(cfg_start),
        .cfg_addr_a(cfg_addr_a), .cfg_addr_b(cfg_addr_b), .cfg_stride(cfg_stride),
        .ID_load_buff_a(ID_load_buff_a), .ID_load_buff_b(ID_load_buff_b), .ID_stall(ID_stall),
        .all_buf_flags(all_buf_flags), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .buf_we(buf_we), .buf_sel(buf_sel), .buf_idx(buf_idx), .buf_wdata(buf_wdata),
        .busy(busy)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // memory model state
    int          gnt_dly = 0;
    int          rlat = 1;
    int          age = 0;
    int          rv_cnt = 0;
    bit          pend = 1'b0;
    logic [31:0] lat_addr = '0;
    logic [31:0] prev_addr = '0;
    bit          prev_wait = 1'b0;
    int          stab_err = 0;
    logic [31:0] gaddr [128];
    int          ng = 0;
    logic [31:0] bufm [2][4];
    int          we_count = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Memory responder: grant after gnt_dly waiting cycles, data rlat cycles later.
    always @(negedge Clk) begin
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        if (pend) begin
            if (rv_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata = mem_f(lat_addr);
                pend = 1'b0;
            end else begin
                rv_cnt--;
            end
        end
        if (mem_req && prev_wait && (mem_addr !== prev_addr)) stab_err++;
        if (mem_req && (mem_addr[1:0] != 2'b00)) stab_err++;
        if (mem_req && !pend) begin
            if (age >= gnt_dly) begin
                mem_gnt = 1'b1;
                pend = 1'b1;
                rv_cnt = rlat - 1;
                lat_addr = mem_addr;
                if (ng < 128) gaddr[ng] = mem_addr;
                ng++;
                age = 0;
            end else begin
                age++;
            end
        end
        prev_wait = mem_req && !mem_gnt;
        prev_addr = mem_addr;
    end

    // Buffer shadow written from the DUT write strobe.
    always @(negedge Clk) begin
        if (buf_we) begin
            bufm[buf_sel][buf_idx] = buf_wdata;
            we_count++;
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        cfg_addr_a = a;
        cfg_addr_b = b;
        cfg_stride = 32'h40;
        cfg_start = 1'b1;
        step(1);
        cfg_start = 1'b0;
    endtask

    task automatic wait_flag(input int maxc);
        for (int i = 0; i < maxc && !all_buf_flags; i++) step(1);
    endtask

    task automatic chk_bank(input string tag, input int bank, input logic [31:0] base);
        for (int i = 0; i < 4; i++)
            chk(tag, bufm[bank][i], mem_f(base + 32'(4 * i)));
    endtask

    task automatic chk_grants(input string tag, input int gb, input logic [31:0] base);
        for (int i = 0; i < 4; i++)
            chk(tag, gaddr[gb + i], base + 32'(4 * i));
    endtask

    int gb;
    int wec;

    initial begin
        // 1: reset held 3 cycles, released without cfg_start
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b1;
        step(2);
        chk("reset_outputs", {mem_req, mem_addr, buf_we, buf_sel, buf_idx, buf_wdata, busy, all_buf_flags}, '0);
        step(3);
        chk("idle_no_req", {mem_req, busy}, '0);

        // 2: initial fill of A then B with zero-wait memory
        gb = ng;
        start(32'h100, 32'h200);
        chk("first_req", {mem_req, busy, mem_addr}, {1'b1, 1'b1, 32'h100});
        step(15);
        chk("flag_before_16", all_buf_flags, 1'b0);
        step(1);
        chk("flag_at_16", all_buf_flags, 1'b1);
        chk("ready_state", {busy, mem_req, buf_we, buf_sel, buf_idx}, {1'b0, 1'b0, 1'b1, 1'b1, 2'd3});
        step(1);
        chk_grants("grants_a", gb, 32'h100);
        chk_grants("grants_b", gb + 4, 32'h200);
        chk_bank("bank_a_data", 0, 32'h100);
        chk_bank("bank_b_data", 1, 32'h200);

        // 3: stalled load does nothing; unstalled load refills A from ptr+stride
        ID_load_buff_a = 1'b1;
        ID_stall = 1'b1;
        step(1);
        chk("stalled_load", {all_buf_flags, mem_req, busy}, {1'b1, 1'b0, 1'b0});
        ID_stall = 1'b0;
        gb = ng;
        step(1);
        ID_load_buff_a = 1'b0;
        chk("consume_a", {all_buf_flags, mem_req, mem_addr}, {1'b0, 1'b1, 32'h140});
        step(7);
        chk("refill_a_pending", all_buf_flags, 1'b0);
        step(1);
        chk("refill_a_done", all_buf_flags, 1'b1);
        step(1);
        chk_grants("grants_a2", gb, 32'h140);
        chk_bank("bank_a2_data", 0, 32'h140);

        // consume both banks at once: A refilled first, then B
        ID_load_buff_a = 1'b1;
        ID_load_buff_b = 1'b1;
        gb = ng;
        step(1);
        ID_load_buff_a = 1'b0;
        ID_load_buff_b = 1'b0;
        chk("consume_both", {all_buf_flags, mem_addr}, {1'b0, 32'h180});
        step(15);
        chk("both_pending", all_buf_flags, 1'b0);
        step(1);
        chk("both_done", all_buf_flags, 1'b1);
        chk("both_b_addr", gaddr[gb + 4], 32'h240);

        // 4: slow memory, grant after 3 cycles, data 2 cycles after grant
        step(1);
        gnt_dly = 3;
        rlat = 2;
        gb = ng;
        start(32'h300, 32'h400);
        step(2);
        chk("held_req", {mem_req, mem_addr}, {1'b1, 32'h300});
        wait_flag(200);
        chk("slow_flag", all_buf_flags, 1'b1);
        step(1);
        chk_grants("slow_grants_a", gb, 32'h300);
        chk_bank("slow_bank_a", 0, 32'h300);
        chk_bank("slow_bank_b", 1, 32'h400);
        chk("req_stability", stab_err, 0);

        // 5: restart while a read is outstanding; stale word must be dropped
        gnt_dly = 0;
        rlat = 3;
        start(32'h700, 32'h800);
        for (int i = 0; i < 20 && !pend; i++) step(1);
        chk("stale_granted", pend, 1'b1);
        wec = we_count;
        gb = ng;
        start(32'h500, 32'h600);
        wait_flag(300);
        chk("drain_flag", all_buf_flags, 1'b1);
        step(1);
        chk("drain_we_count", we_count - wec, 8);
        chk("drain_first_addr", gaddr[gb], 32'h500);
        chk_bank("drain_bank_a", 0, 32'h500);
        chk("drain_bank_b3", bufm[1][3], mem_f(32'h60C));

        // 6: reset mid-fill of B with a read in flight
        start(32'h900, 32'hA00);
        for (int i = 0; i < 300 && !(pend && lat_addr == 32'hA04); i++) step(1);
        chk("midfill_b", lat_addr, 32'hA04);
        Reset = 1'b0;
        wec = we_count;
        step(1);
        Reset = 1'b1;
        chk("reset_midfill", {mem_req, busy, all_buf_flags, buf_we}, '0);
        step(5);
        chk("stale_after_reset", we_count - wec, 0);
        chk("idle_after_reset", {mem_req, busy, all_buf_flags, buf_we}, '0);
        chk("stale_delivered", pend, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
